// File: rtl/cen_rate_meter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cen_rate_meter_pkg                                                 |
// | Shared types, default widths and helpers for the CEN rate meter.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cen_rate_meter_pkg;

   localparam int unsigned DEF_WIN_W = 20;
   localparam int unsigned DEF_CNT_W = 16;
   localparam int unsigned DEF_GAP_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SYNC    = 2'd1,
      ST_MEASURE = 2'd2,
      ST_REPORT  = 2'd3
   } state_t;

   // Increment that sticks at the all-ones value of a WIDTH-bit counter.
   // WIDTH must be below 32; callers cast the result back to their width.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input int unsigned width);
      logic [31:0] lim;
      lim = (32'd1 << width) - 32'd1;
      return (val >= lim) ? lim : (val + 32'd1);
   endfunction

endpackage : cen_rate_meter_pkg
`default_nettype wire

// File: rtl/cen_gap_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cen_gap_tracker                                                    |
// | Tracks cycles since the last CEN pulse and keeps the largest       |
// | pulse-to-pulse distance seen while enabled. Saturating.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cen_gap_tracker
   import cen_rate_meter_pkg::*;
#(
   parameter int unsigned GAP_W = DEF_GAP_W
)
(
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             cen_i,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic [GAP_W-1:0] gap_max_o
);

   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] max_q, max_d;
   logic [GAP_W-1:0] gap_inc;

   // gap+1 is both the idle-cycle step and the distance closed by a pulse
   assign gap_inc = GAP_W'(sat_inc(32'(gap_q), GAP_W));

   // Next-state: clear on a new measurement, otherwise track while enabled
   always_comb begin
      gap_d = gap_q;
      max_d = max_q;
      if (clear_i) begin
         gap_d = '0;
         max_d = '0;
      end else if (enable_i) begin
         if (cen_i) begin
            if (gap_inc > max_q) begin
               max_d = gap_inc;
            end
            gap_d = '0;
         end else begin
            gap_d = gap_inc;
         end
      end
   end

   // Gap counter and maximum registers
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         gap_q <= '0;
         max_q <= '0;
      end else begin
         gap_q <= gap_d;
         max_q <= max_d;
      end
   end

   assign gap_max_o = max_q;

endmodule : cen_gap_tracker
`default_nettype wire

// File: rtl/cen_rate_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cen_rate_meter                                                     |
// | Counts CEN pulses over a programmable window aligned to a pulse,   |
// | reports count, maximum gap, CEN/CENB collision and pass/fail.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cen_rate_meter
   import cen_rate_meter_pkg::*;
#(
   parameter int unsigned WIN_W = DEF_WIN_W,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned GAP_W = DEF_GAP_W
)
(
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             CEN_IN,
   input  logic             CENB_IN,
   input  logic             START,
   input  logic [WIN_W-1:0] WINDOW,
   input  logic [CNT_W-1:0] EXP_MIN,
   input  logic [CNT_W-1:0] EXP_MAX,
   output logic             BUSY,
   output logic             DONE,
   output logic [CNT_W-1:0] COUNT,
   output logic [GAP_W-1:0] GAP_MAX,
   output logic             OVERLAP_ERR,
   output logic             TIMEOUT,
   output logic             PASS
);

   state_t           state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] max_q, max_d;
   // Cycles left in the current phase, including the present cycle
   logic [WIN_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovl_q, ovl_d;
   logic             tmo_q, tmo_d;
   logic             pass_q, pass_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             accept;
   logic             in_sync;
   logic             in_meas;
   logic             in_rep;
   logic             last_cyc;

   // The DONE cycle is already IDLE but must still refuse START
   assign accept   = (state_q == ST_IDLE) && START && !done_q;
   assign last_cyc = (wcnt_q == WIN_W'(1));

   // State register
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = (WINDOW == '0) ? ST_REPORT : ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (CEN_IN) begin
               // a one-cycle window is just the sync cycle itself
               state_d = (win_q == WIN_W'(1)) ? ST_REPORT : ST_MEASURE;
            end else if (last_cyc) begin
               state_d = ST_REPORT;
            end
         end
         ST_MEASURE: begin
            if (last_cyc) begin
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State decode driving the datapath
   always_comb begin
      in_sync = 1'b0;
      in_meas = 1'b0;
      in_rep  = 1'b0;
      unique case (state_q)
         ST_SYNC:    in_sync = 1'b1;
         ST_MEASURE: in_meas = 1'b1;
         ST_REPORT:  in_rep  = 1'b1;
         default:    ;
      endcase
   end

   // Datapath next-state: config latch, window count, pulse count, flags
   always_comb begin
      win_d   = win_q;
      min_d   = min_q;
      max_d   = max_q;
      wcnt_d  = wcnt_q;
      count_d = count_q;
      ovl_d   = ovl_q;
      tmo_d   = tmo_q;
      pass_d  = pass_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (accept) begin
         win_d   = WINDOW;
         min_d   = EXP_MIN;
         max_d   = EXP_MAX;
         wcnt_d  = WINDOW;
         count_d = '0;
         ovl_d   = 1'b0;
         tmo_d   = 1'b0;
         pass_d  = 1'b0;
         busy_d  = 1'b1;
      end else if (in_sync) begin
         if (CEN_IN) begin
            count_d = CNT_W'(1);
            wcnt_d  = win_q - WIN_W'(1);
            ovl_d   = ovl_q | CENB_IN;
         end else if (last_cyc) begin
            tmo_d = 1'b1;
         end else begin
            wcnt_d = wcnt_q - WIN_W'(1);
         end
      end else if (in_meas) begin
         wcnt_d = wcnt_q - WIN_W'(1);
         if (CEN_IN) begin
            count_d = CNT_W'(sat_inc(32'(count_q), CNT_W));
            ovl_d   = ovl_q | CENB_IN;
         end
      end else if (in_rep) begin
         pass_d = (count_q >= min_q) && (count_q <= max_q) && !ovl_q && !tmo_q;
         done_d = 1'b1;
         busy_d = 1'b0;
      end
   end

   // Datapath registers
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         win_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         wcnt_q  <= '0;
         count_q <= '0;
         ovl_q   <= 1'b0;
         tmo_q   <= 1'b0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         win_q   <= win_d;
         min_q   <= min_d;
         max_q   <= max_d;
         wcnt_q  <= wcnt_d;
         count_q <= count_d;
         ovl_q   <= ovl_d;
         tmo_q   <= tmo_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   cen_gap_tracker #(
      .GAP_W (GAP_W)
   ) u_gap (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .cen_i     (CEN_IN),
      .clear_i   (accept),
      .enable_i  (in_meas),
      .gap_max_o (GAP_MAX)
   );

   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign COUNT       = count_q;
   assign OVERLAP_ERR = ovl_q;
   assign TIMEOUT     = tmo_q;
   assign PASS        = pass_q;

endmodule : cen_rate_meter
`default_nettype wire

// File: tb/tb_cen_rate_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cen_rate_meter                                                  |
// | Directed scoreboard bench: one 16-bit-count meter and one 4-bit    |
// | count meter for saturation.                                        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cen_rate_meter;

   typedef struct {
      int count;
      int gap;
      int ovl;
      int tmo;
      int pass;
      int lat;
      int start;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        CEN_IN, CENB_IN;
   logic        START_A, START_B;
   logic [19:0] WINDOW;
   logic [15:0] EXP_MIN, EXP_MAX;
   logic [3:0]  EXP_MIN_B, EXP_MAX_B;

   logic        BUSY_A, DONE_A, OVL_A, TMO_A, PASS_A;
   logic [15:0] COUNT_A;
   logic [7:0]  GAP_A;
   logic        BUSY_B, DONE_B, OVL_B, TMO_B, PASS_B;
   logic [3:0]  COUNT_B;
   logic [7:0]  GAP_B;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   mode     = 0;
   int   per      = 1;
   bit   same     = 1'b0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   cen_rate_meter #(.WIN_W(20), .CNT_W(16), .GAP_W(8)) u_dut_a (
      .CLK(CLK), .RESET_N(RESET_N), .CEN_IN(CEN_IN), .CENB_IN(CENB_IN),
      .START(START_A), .WINDOW(WINDOW), .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX),
      .BUSY(BUSY_A), .DONE(DONE_A), .COUNT(COUNT_A), .GAP_MAX(GAP_A),
      .OVERLAP_ERR(OVL_A), .TIMEOUT(TMO_A), .PASS(PASS_A)
   );

   cen_rate_meter #(.WIN_W(20), .CNT_W(4), .GAP_W(8)) u_dut_b (
      .CLK(CLK), .RESET_N(RESET_N), .CEN_IN(CEN_IN), .CENB_IN(CENB_IN),
      .START(START_B), .WINDOW(WINDOW), .EXP_MIN(EXP_MIN_B), .EXP_MAX(EXP_MAX_B),
      .BUSY(BUSY_B), .DONE(DONE_B), .COUNT(COUNT_B), .GAP_MAX(GAP_B),
      .OVERLAP_ERR(OVL_B), .TIMEOUT(TMO_B), .PASS(PASS_B)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // CEN/CENB pattern generator: 0 idle, 1 periodic 1-of-per, 2 9-of-128, 3 constant
   initial begin
      int pc;
      int acc;
      logic [6:0] dl;
      pc = 0; acc = 0; dl = '0;
      CEN_IN = 1'b0; CENB_IN = 1'b0;
      forever begin
         @(negedge CLK);
         case (mode)
            1: begin
               CEN_IN  = (pc == 0);
               CENB_IN = same ? (pc == 0) : 1'b0;
               pc      = (pc + 1 >= per) ? 0 : pc + 1;
            end
            2: begin
               acc = acc + 9;
               if (acc >= 128) begin
                  acc = acc - 128;
                  CEN_IN = 1'b1;
               end else begin
                  CEN_IN = 1'b0;
               end
               CENB_IN = dl[6];
               dl = {dl[5:0], CEN_IN};
            end
            3: begin
               CEN_IN = 1'b1; CENB_IN = 1'b0;
            end
            default: begin
               CEN_IN = 1'b0; CENB_IN = 1'b0;
            end
         endcase
      end
   end

   // Monitor for meter A
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (DONE_A === 1'b1) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_done", 32'(DONE_A), 32'd0);
            end else begin
               e = qa.pop_front();
               chk("a_count", 32'(COUNT_A), e.count);
               chk("a_gap_max", 32'(GAP_A), e.gap);
               chk("a_overlap", 32'(OVL_A), e.ovl);
               chk("a_timeout", 32'(TMO_A), e.tmo);
               chk("a_pass", 32'(PASS_A), e.pass);
               chk("a_busy_with_done", 32'(BUSY_A), 32'd0);
               if (e.lat >= 0) chk("a_latency", cyc - e.start, e.lat);
               @(negedge CLK);
               chk("a_done_one_cycle", 32'(DONE_A), 32'd0);
            end
         end
      end
   end

   // Monitor for meter B
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (DONE_B === 1'b1) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_done", 32'(DONE_B), 32'd0);
            end else begin
               e = qb.pop_front();
               chk("b_count", 32'(COUNT_B), e.count);
               chk("b_gap_max", 32'(GAP_B), e.gap);
               chk("b_overlap", 32'(OVL_B), e.ovl);
               chk("b_timeout", 32'(TMO_B), e.tmo);
               chk("b_pass", 32'(PASS_B), e.pass);
               if (e.lat >= 0) chk("b_latency", cyc - e.start, e.lat);
               @(negedge CLK);
               chk("b_done_one_cycle", 32'(DONE_B), 32'd0);
            end
         end
      end
   end

   task automatic start_a(input int w, input int mn, input int mx, input bit push, input exp_t e);
      @(negedge CLK);
      WINDOW = 20'(w); EXP_MIN = 16'(mn); EXP_MAX = 16'(mx); START_A = 1'b1;
      e.start = cyc;
      if (push) qa.push_back(e);
      @(negedge CLK);
      START_A = 1'b0;
   endtask

   task automatic start_b(input int w, input int mn, input int mx, input exp_t e);
      @(negedge CLK);
      WINDOW = 20'(w); EXP_MIN_B = 4'(mn); EXP_MAX_B = 4'(mx); START_B = 1'b1;
      e.start = cyc;
      qb.push_back(e);
      @(negedge CLK);
      START_B = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (qa.size() != 0 || qb.size() != 0) begin
         chk("done_timeout_pending", qa.size() + qb.size(), 0);
         qa.delete();
         qb.delete();
      end
      repeat (3) @(negedge CLK);
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, "_busy"}, 32'(BUSY_A), 0);
      chk({tag, "_done"}, 32'(DONE_A), 0);
      chk({tag, "_count"}, 32'(COUNT_A), 0);
      chk({tag, "_gap"}, 32'(GAP_A), 0);
      chk({tag, "_overlap"}, 32'(OVL_A), 0);
      chk({tag, "_timeout"}, 32'(TMO_A), 0);
      chk({tag, "_pass"}, 32'(PASS_A), 0);
   endtask

   initial begin
      int n;
      RESET_N = 1'b0; START_A = 1'b0; START_B = 1'b0;
      WINDOW = '0; EXP_MIN = '0; EXP_MAX = '0; EXP_MIN_B = '0; EXP_MAX_B = '0;
      repeat (3) @(negedge CLK);
      chk_a_zero("reset");
      RESET_N = 1'b1;

      // 1-of-24, 100 pulses in 2400 cycles
      mode = 1; per = 24; same = 1'b0;
      start_a(2400, 99, 101, 1'b1, '{100, 24, 0, 0, 1, -1, 0});
      drain(3000);

      // 9-of-128 fractional with CENB offset by 7 cycles
      mode = 2;
      start_a(1280, 90, 90, 1'b1, '{90, 15, 0, 0, 1, -1, 0});
      drain(2000);

      // No CEN: timeout, DONE 102 cycles after START
      mode = 0;
      start_a(100, 0, 10, 1'b1, '{0, 0, 0, 1, 0, 102, 0});
      drain(300);

      // CEN and CENB identical at 1-of-18
      mode = 1; per = 18; same = 1'b1;
      start_a(180, 10, 10, 1'b1, '{10, 18, 1, 0, 0, -1, 0});
      drain(400);

      // 4-bit counter saturates under constant CEN; then a zero window
      mode = 3;
      start_b(40, 0, 15, '{15, 1, 0, 0, 1, -1, 0});
      drain(200);
      start_b(0, 0, 0, '{0, 0, 0, 0, 1, 2, 0});
      drain(50);

      // Reset in the middle of a measurement: no DONE, everything cleared
      mode = 1; per = 24; same = 1'b0;
      start_a(2400, 99, 101, 1'b0, '{0, 0, 0, 0, 0, -1, 0});
      repeat (200) @(negedge CLK);
      chk("mid_busy_before_reset", 32'(BUSY_A), 1);
      RESET_N = 1'b0;
      repeat (2) @(negedge CLK);
      chk_a_zero("mid_reset");
      RESET_N = 1'b1;
      repeat (2600) @(negedge CLK);
      chk("after_abort_busy", 32'(BUSY_A), 0);

      // START during BUSY and in the DONE cycle are both ignored
      mode = 1; per = 18; same = 1'b0;
      start_a(180, 10, 10, 1'b1, '{10, 18, 0, 0, 1, -1, 0});
      repeat (20) @(negedge CLK);
      WINDOW = 20'd5; EXP_MIN = 16'd0; EXP_MAX = 16'd0; START_A = 1'b1;
      @(negedge CLK);
      START_A = 1'b0;
      n = 0;
      while (DONE_A !== 1'b1 && n < 400) begin
         @(negedge CLK);
         n++;
      end
      chk("busy_start_done_seen", 32'(DONE_A), 1);
      WINDOW = 20'd3; START_A = 1'b1;
      @(negedge CLK);
      START_A = 1'b0;
      chk("done_cycle_start_busy", 32'(BUSY_A), 0);
      chk("hold_count", 32'(COUNT_A), 10);
      chk("hold_pass", 32'(PASS_A), 1);
      repeat (20) @(negedge CLK);
      chk("hold_count_later", 32'(COUNT_A), 10);
      chk("hold_gap_later", 32'(GAP_A), 18);
      drain(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cen_rate_meter
`default_nettype wire
